flu_extract_field: RTL and testbench

- Parametrised successor of the fixed 4-byte FLU extractor.
- Sits on a forked branch of a FLU stream, acting as a sink.
- For each packet, captures EXTRACT_BYTES consecutive bytes starting at a per-packet byte OFFSET, measured from the packet's first byte.
- Emits one result per packet on a valid/ready interface, with a FOUND flag that reports whether the whole field lay inside the packet.
- Handles fields spanning word boundaries, and an EOP of one packet plus a SOP of the next in the same word.

---
 rtl/flu_extract_field_if.sv | 32 +++
 rtl/flu_extract_field.sv | 224 ++++++++++++++++++++++
 tb/tb_flu_extract_field.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/flu_extract_field_if.sv
// FLU receive stream plus extracted-field result channel.
// The master drives RX and consumes EX; the slave is the extractor.
interface flu_extract_field_if #(
    parameter int unsigned DataWidth    = 512,
    parameter int unsigned SopPosWidth  = 3,
    parameter int unsigned EopPosWidth  = $clog2(DataWidth / 8),
    parameter int unsigned OffsetWidth  = 10,
    parameter int unsigned ExtractBytes = 4
);
    logic [DataWidth-1:0]      rx_data;
    logic [SopPosWidth-1:0]    rx_sop_pos;
    logic [EopPosWidth-1:0]    rx_eop_pos;
    logic                      rx_sop;
    logic                      rx_eop;
    logic                      rx_src_rdy;
    logic                      rx_dst_rdy;
    logic [OffsetWidth-1:0]    offset;
    logic [8*ExtractBytes-1:0] ex_data;
    logic                      ex_found;
    logic                      ex_src_rdy;
    logic                      ex_dst_rdy;

    modport master (
        output rx_data, rx_sop_pos, rx_eop_pos, rx_sop, rx_eop, rx_src_rdy, offset, ex_dst_rdy,
        input  rx_dst_rdy, ex_data, ex_found, ex_src_rdy
    );

    modport slave (
        input  rx_data, rx_sop_pos, rx_eop_pos, rx_sop, rx_eop, rx_src_rdy, offset, ex_dst_rdy,
        output rx_dst_rdy, ex_data, ex_found, ex_src_rdy
    );
endinterface

// File: rtl/flu_extract_field.sv
// FLU field extractor: captures ExtractBytes bytes at a per-packet offset and
// emits one result per packet with a flag telling whether the field was complete.
module flu_extract_field #(
    parameter int unsigned DataWidth    = 512,
    parameter int unsigned SopPosWidth  = 3,
    parameter int unsigned EopPosWidth  = $clog2(DataWidth / 8),
    parameter int unsigned OffsetWidth  = 10,
    parameter int unsigned ExtractBytes = 4,
    parameter bit          InputPipe    = 1'b1
) (
    input logic                clk_i,
    input logic                rst_ni,
    flu_extract_field_if.slave bus
);
    localparam int unsigned NumBytes = DataWidth / 8;
    localparam int unsigned BlkBytes = NumBytes >> SopPosWidth;
    // Wide enough for offset + word size + slot index without wrap.
    localparam int unsigned CntW =
        ((OffsetWidth > EopPosWidth) ? OffsetWidth : EopPosWidth) + 2;
    localparam logic [CntW-1:0] NumBytesC = CntW'(NumBytes);
    localparam logic [CntW-1:0] BlkBytesC = CntW'(BlkBytes);
    // Past this count no slot can match any more, so the counter may stop.
    localparam logic [CntW-1:0] CntMax = CntW'((1 << OffsetWidth) + ExtractBytes);

    typedef enum logic [0:0] {StIdle, StInPkt} state_e;
    state_e state_q, state_d;

    logic [DataWidth-1:0]   w_data;
    logic [SopPosWidth-1:0] w_sop_pos;
    logic [EopPosWidth-1:0] w_eop_pos;
    logic                   w_sop, w_eop, w_valid;
    logic [OffsetWidth-1:0] w_offset;
    logic                   stall, proc_en, rdy_q;

    logic                         res_valid_q, res_found_q;
    logic [ExtractBytes-1:0][7:0] res_data_q, res_src;
    logic [ExtractBytes-1:0]      res_v_src;

    logic [ExtractBytes-1:0][7:0] col_q, col_d, old_col, new_col;
    logic [ExtractBytes-1:0]      colv_q, colv_d, old_v, new_v;
    logic [OffsetWidth-1:0]       off_q, off_d;
    logic [CntW-1:0]              cnt_q, cnt_d, cnt_inc;

    logic            in_pkt, close_old, open_new, close_new;
    logic [CntW-1:0] sop_start, eop_pos, idx_old, idx_new, tgt_old;
    logic [7:0]      w_bytes [NumBytes];

    // An EOP word may not be consumed while an unread result blocks the register.
    assign stall          = res_valid_q & ~bus.ex_dst_rdy & w_eop & w_valid;
    assign bus.rx_dst_rdy = rdy_q & ~stall;

    if (InputPipe) begin : g_pipe
        logic                   p_valid_q, p_sop_q, p_eop_q;
        logic [DataWidth-1:0]   p_data_q;
        logic [SopPosWidth-1:0] p_sop_pos_q;
        logic [EopPosWidth-1:0] p_eop_pos_q;
        logic [OffsetWidth-1:0] p_offset_q;

        // Input register stage; refills in the same cycle it drains.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                p_valid_q   <= 1'b0;
                p_sop_q     <= 1'b0;
                p_eop_q     <= 1'b0;
                p_data_q    <= '0;
                p_sop_pos_q <= '0;
                p_eop_pos_q <= '0;
                p_offset_q  <= '0;
            end else if (bus.rx_src_rdy && bus.rx_dst_rdy) begin
                p_valid_q   <= 1'b1;
                p_sop_q     <= bus.rx_sop;
                p_eop_q     <= bus.rx_eop;
                p_data_q    <= bus.rx_data;
                p_sop_pos_q <= bus.rx_sop_pos;
                p_eop_pos_q <= bus.rx_eop_pos;
                p_offset_q  <= bus.offset;
            end else if (proc_en) begin
                p_valid_q <= 1'b0;
            end
        end

        assign w_valid   = p_valid_q;
        assign w_sop     = p_sop_q;
        assign w_eop     = p_eop_q;
        assign w_data    = p_data_q;
        assign w_sop_pos = p_sop_pos_q;
        assign w_eop_pos = p_eop_pos_q;
        assign w_offset  = p_offset_q;
        assign proc_en   = p_valid_q & ~stall;
    end else begin : g_nopipe
        assign w_valid   = 1'b1;
        assign w_sop     = bus.rx_sop;
        assign w_eop     = bus.rx_eop;
        assign w_data    = bus.rx_data;
        assign w_sop_pos = bus.rx_sop_pos;
        assign w_eop_pos = bus.rx_eop_pos;
        assign w_offset  = bus.offset;
        assign proc_en   = bus.rx_src_rdy & bus.rx_dst_rdy;
    end

    // Ready comes up one cycle after reset release.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) rdy_q <= 1'b0;
        else         rdy_q <= 1'b1;
    end

    // Packet state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Next state: a SOP always opens (possibly closing in the same word).
    always_comb begin
        state_d = state_q;
        if (open_new)       state_d = close_new ? StIdle : StInPkt;
        else if (close_old) state_d = StIdle;
    end

    // Word decode: which packet(s) the processed word closes or opens.
    always_comb begin
        sop_start = CntW'(w_sop_pos) * BlkBytesC;
        eop_pos   = CntW'(w_eop_pos);
        in_pkt    = (state_q == StInPkt);
        open_new  = proc_en & w_sop;
        close_new = open_new & w_eop & (eop_pos >= sop_start);
        close_old = proc_en & in_pkt & w_eop & (~w_sop | (eop_pos < sop_start));
    end

    // Byte view of the working word.
    always_comb begin
        for (int unsigned b = 0; b < NumBytes; b++) w_bytes[b] = w_data[8*b +: 8];
    end

    // Per-slot capture for the continuing packet and for a packet starting here.
    always_comb begin
        old_col = col_q;
        old_v   = colv_q;
        new_col = '0;
        new_v   = '0;
        tgt_old = '0;
        idx_old = '0;
        idx_new = '0;
        for (int unsigned k = 0; k < ExtractBytes; k++) begin
            tgt_old = CntW'(off_q) + CntW'(k);
            idx_old = tgt_old - cnt_q;
            if (in_pkt && (tgt_old >= cnt_q) && (idx_old < NumBytesC) &&
                (!w_sop || idx_old < sop_start) && (!close_old || idx_old <= eop_pos)) begin
                old_col[k] = w_bytes[idx_old[EopPosWidth-1:0]];
                old_v[k]   = 1'b1;
            end
            idx_new = sop_start + CntW'(w_offset) + CntW'(k);
            if (w_sop && (idx_new < NumBytesC) && (!close_new || idx_new <= eop_pos)) begin
                new_col[k] = w_bytes[idx_new[EopPosWidth-1:0]];
                new_v[k]   = 1'b1;
            end
        end
    end

    // Collector next state; a new SOP discards whatever the old packet left.
    always_comb begin
        col_d   = col_q;
        colv_d  = colv_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + NumBytesC;
        if (open_new) begin
            col_d  = new_col;
            colv_d = new_v;
            off_d  = w_offset;
            cnt_d  = NumBytesC - sop_start;
        end else if (close_old) begin
            col_d  = '0;
            colv_d = '0;
            cnt_d  = '0;
        end else if (proc_en && in_pkt) begin
            col_d  = old_col;
            colv_d = old_v;
            cnt_d  = (cnt_inc > CntMax) ? CntMax : cnt_inc;
        end
    end

    // Collector registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            col_q  <= '0;
            colv_q <= '0;
            off_q  <= '0;
            cnt_q  <= '0;
        end else begin
            col_q  <= col_d;
            colv_q <= colv_d;
            off_q  <= off_d;
            cnt_q  <= cnt_d;
        end
    end

    // Result source: the closing packet, with uncaptured slots zeroed.
    always_comb begin
        res_v_src = close_old ? old_v : new_v;
        for (int unsigned k = 0; k < ExtractBytes; k++) begin
            res_src[k] = res_v_src[k] ? (close_old ? old_col[k] : new_col[k]) : 8'h00;
        end
    end

    // Result register; held until the consumer takes it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_found_q <= 1'b0;
        end else if (close_old || close_new) begin
            res_valid_q <= 1'b1;
            res_data_q  <= res_src;
            res_found_q <= &res_v_src;
        end else if (bus.ex_dst_rdy) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.ex_data    = res_data_q;
    assign bus.ex_found   = res_found_q;
    assign bus.ex_src_rdy = res_valid_q;
endmodule

// File: tb/tb_flu_extract_field.sv
// Directed bench for flu_extract_field (512-bit, 8-byte field, no input pipe).
module tb_flu_extract_field;
    localparam logic [511:0] Filler = {64{8'hEE}};

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_stall = 0;
    int   word_idx = 0;
    int   first_stall_idx = -1;
    int   rx_xfers = 0;
    logic [63:0] got_data [$];
    logic        got_found [$];

    always #5 clk = ~clk;

    flu_extract_field_if #(
        .DataWidth(512), .SopPosWidth(3), .EopPosWidth(6), .OffsetWidth(10), .ExtractBytes(8)
    ) bus ();

    flu_extract_field #(
        .DataWidth(512), .SopPosWidth(3), .EopPosWidth(6), .OffsetWidth(10),
        .ExtractBytes(8), .InputPipe(1'b0)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Record result and RX transfers half a cycle ahead of the edge that commits them.
    always @(negedge clk) begin
        if (rst_n && bus.ex_src_rdy && bus.ex_dst_rdy) begin
            got_data.push_back(bus.ex_data);
            got_found.push_back(bus.ex_found);
        end
        if (rst_n && bus.rx_src_rdy && bus.rx_dst_rdy) rx_xfers <= rx_xfers + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic logic [511:0] put_seg(input logic [511:0] d, input int first_b,
                                             input int last_b, input int start_p);
        logic [511:0] r;
        r = d;
        for (int b = first_b; b <= last_b; b++) r[8*b +: 8] = 8'((start_p + b - first_b) % 256);
        return r;
    endfunction

    task automatic send_word(input logic [511:0] d, input logic sop, input int sop_pos,
                             input logic eop, input int eop_pos, input int off);
        int n;
        bus.rx_data    = d;
        bus.rx_sop     = sop;
        bus.rx_sop_pos = 3'(sop_pos);
        bus.rx_eop     = eop;
        bus.rx_eop_pos = 6'(eop_pos);
        bus.offset     = 10'(off);
        bus.rx_src_rdy = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.rx_dst_rdy) begin
                @(posedge clk); #1;
                break;
            end
            n_stall++;
            if (first_stall_idx < 0) first_stall_idx = word_idx;
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                check_eq("send_timeout", 64'(n), 0);
                break;
            end
        end
        bus.rx_src_rdy = 1'b0;
        bus.rx_sop     = 1'b0;
        bus.rx_eop     = 1'b0;
        word_idx++;
    endtask

    task automatic expect_result(input string tag, input logic [63:0] d, input logic f);
        int n;
        n = 0;
        while (got_data.size() == 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_avail"}, 64'(got_data.size() > 0), 1);
        if (got_data.size() > 0) begin
            check_eq({tag, "_data"}, got_data.pop_front(), d);
            check_eq({tag, "_found"}, 64'(got_found.pop_front()), 64'(f));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [511:0] w;
        int x0, s0;
        rst_n          = 1'b0;
        bus.rx_data    = '0;
        bus.rx_sop     = 1'b0;
        bus.rx_eop     = 1'b0;
        bus.rx_sop_pos = '0;
        bus.rx_eop_pos = '0;
        bus.rx_src_rdy = 1'b0;
        bus.offset     = '0;
        bus.ex_dst_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rx_dst_rdy", 64'(bus.rx_dst_rdy), 0);
        check_eq("rst_ex_src_rdy", 64'(bus.ex_src_rdy), 0);
        check_eq("rst_ex_data", bus.ex_data, 0);
        check_eq("rst_ex_found", 64'(bus.ex_found), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rdy_after_reset", 64'(bus.rx_dst_rdy), 1);

        // 1: single 64 B word, offset 12
        check_eq("t1_idle_src_rdy", 64'(bus.ex_src_rdy), 0);
        send_word(put_seg(Filler, 0, 63, 0), 1'b1, 0, 1'b1, 63, 12);
        check_eq("t1_latency", 64'(bus.ex_src_rdy), 1);
        expect_result("t1", 64'h13121110_0F0E0D0C, 1'b1);

        // 2: start in last block, field straddles the word boundary
        send_word(put_seg(Filler, 56, 63, 0), 1'b1, 7, 1'b0, 0, 4);
        send_word(put_seg(Filler, 0, 63, 8), 1'b0, 0, 1'b0, 0, 0);
        send_word(put_seg(Filler, 0, 27, 72), 1'b0, 0, 1'b1, 27, 0);
        expect_result("t2", 64'h0B0A0908_07060504, 1'b1);

        // 3: field runs past the end, and offset far past the end
        send_word(put_seg(Filler, 0, 63, 0), 1'b1, 0, 1'b1, 63, 60);
        expect_result("t3a", 64'h00000000_3F3E3D3C, 1'b0);
        send_word(put_seg(Filler, 0, 63, 0), 1'b1, 0, 1'b1, 63, 1023);
        expect_result("t3b", 64'h0, 1'b0);

        // 4: EOP of A and SOP of B share a word
        s0 = n_stall;
        send_word(put_seg(Filler, 0, 63, 0), 1'b1, 0, 1'b0, 0, 0);
        w = put_seg(put_seg(Filler, 0, 31, 64), 32, 63, 0);
        send_word(w, 1'b1, 4, 1'b1, 31, 0);
        send_word(put_seg(Filler, 0, 31, 32), 1'b0, 0, 1'b1, 31, 0);
        expect_result("t4_a", 64'h07060504_03020100, 1'b1);
        expect_result("t4_b", 64'h07060504_03020100, 1'b1);
        check_eq("t4_no_stall", 64'(n_stall - s0), 0);

        // 4b: same shape, offsets ending on A's last byte and inside B's next word
        send_word(put_seg(Filler, 0, 63, 0), 1'b1, 0, 1'b0, 0, 88);
        send_word(w, 1'b1, 4, 1'b1, 31, 40);
        send_word(put_seg(Filler, 0, 31, 32), 1'b0, 0, 1'b1, 31, 0);
        expect_result("t4b_a", 64'h5F5E5D5C_5B5A5958, 1'b1);
        expect_result("t4b_b", 64'h2F2E2D2C_2B2A2928, 1'b1);

        // 5: consumer blocked for 20 cycles, three single-word packets
        first_stall_idx = -1;
        s0 = word_idx;
        x0 = rx_xfers;
        bus.ex_dst_rdy = 1'b0;
        fork
            begin
                send_word(put_seg(Filler, 0, 63, 0), 1'b1, 0, 1'b1, 63, 0);
                send_word(put_seg(Filler, 0, 63, 0), 1'b1, 0, 1'b1, 63, 8);
                send_word(put_seg(Filler, 0, 63, 0), 1'b1, 0, 1'b1, 63, 16);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                bus.ex_dst_rdy = 1'b1;
            end
        join
        check_eq("t5_stall_word", 64'(first_stall_idx - s0), 1);
        expect_result("t5_r0", 64'h07060504_03020100, 1'b1);
        expect_result("t5_r1", 64'h0F0E0D0C_0B0A0908, 1'b1);
        expect_result("t5_r2", 64'h17161514_13121110, 1'b1);
        check_eq("t5_rx_words", 64'(rx_xfers - x0), 3);

        // 6: reset in the middle of a 200 B packet
        send_word(put_seg(Filler, 0, 63, 0), 1'b1, 0, 1'b0, 0, 0);
        send_word(put_seg(Filler, 0, 63, 64), 1'b0, 0, 1'b0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("t6_ex_src_rdy", 64'(bus.ex_src_rdy), 0);
        check_eq("t6_rx_dst_rdy", 64'(bus.rx_dst_rdy), 0);
        send_word(put_seg(Filler, 0, 63, 128), 1'b0, 0, 1'b0, 0, 0);
        send_word(put_seg(Filler, 0, 7, 192), 1'b0, 0, 1'b1, 7, 0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("t6_no_result", 64'(got_data.size()), 0);
        check_eq("t6_src_idle", 64'(bus.ex_src_rdy), 0);
        send_word(put_seg(Filler, 0, 63, 0), 1'b1, 0, 1'b1, 63, 0);
        expect_result("t6_next", 64'h07060504_03020100, 1'b1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
